// File: rtl/ex_div_if.sv
// EX-stage divider handshake: decoded divide op and operands in, stall request and result out.
// master = pipeline side (ID/EX register, pause controller), slave = divider.
interface ex_div_if;
  logic        exception_flush;
  logic        ex_stall;
  logic        op_valid;
  logic        op_signed;
  logic        op_mod;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        pause_request;
  logic        result_valid;
  logic [31:0] result;

  modport master (
    output exception_flush, ex_stall, op_valid, op_signed, op_mod, src1, src2,
    input  pause_request, result_valid, result
  );

  modport slave (
    input  exception_flush, ex_stall, op_valid, op_signed, op_mod, src1, src2,
    output pause_request, result_valid, result
  );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring 32-bit divider for div.w/div.wu/mod.w/mod.wu.
// Stalls IF..EX while busy and holds its result until the downstream stall clears.
module ex_div #(
  parameter logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF,
  parameter int          ITERATIONS = 32
) (
  input  logic   clk,
  input  logic   rst,
  ex_div_if.slave bus
);

  localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  count_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] div_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;
  logic        mod_reg;
  logic [31:0] result_reg;

  // Operand magnitudes presented at the IDLE->BUSY edge.
  logic [31:0] dividend_mag;
  logic [31:0] divisor_mag;
  logic        divide_by_zero;

  assign dividend_mag   = (bus.op_signed && bus.src1[31]) ? (~bus.src1 + 32'd1) : bus.src1;
  assign divisor_mag    = (bus.op_signed && bus.src2[31]) ? (~bus.src2 + 32'd1) : bus.src2;
  assign divide_by_zero = (bus.src2 == 32'd0);

  // One restoring step. The shifted partial remainder needs 33 bits; after the
  // conditional subtract it is always below the divisor and fits in 32 again.
  logic [32:0] rem_shift;
  logic [31:0] quo_shift;
  logic        rem_ge;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  assign rem_shift = {rem_reg, quo_reg[31]};
  assign quo_shift = {quo_reg[30:0], 1'b0};
  assign rem_ge    = (rem_shift >= {1'b0, div_reg});
  assign rem_step  = rem_ge ? (rem_shift[31:0] - div_reg) : rem_shift[31:0];
  assign quo_step  = {quo_shift[31:1], rem_ge};

  // Sign correction applied to the final step, so the result register loads on BUSY->DONE.
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] result_sel;

  assign quo_fixed = q_neg_reg ? (~quo_step + 32'd1) : quo_step;
  assign rem_fixed = r_neg_reg ? (~rem_step + 32'd1) : rem_step;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_result_sel
      assign result_sel[gi] = mod_reg ? rem_fixed[gi] : quo_fixed[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.op_valid) begin
          state_next = divide_by_zero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count_reg == LAST_COUNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.ex_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (bus.exception_flush) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= 6'd0;
      rem_reg    <= 32'd0;
      quo_reg    <= 32'd0;
      div_reg    <= 32'd0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      mod_reg    <= 1'b0;
      result_reg <= 32'd0;
    end else if (bus.exception_flush) begin
      count_reg <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          count_reg <= 6'd0;
          if (bus.op_valid) begin
            if (divide_by_zero) begin
              // Remainder of x/0 is the dividend itself, bit for bit.
              result_reg <= bus.op_mod ? bus.src1 : DIV_ZERO_Q;
            end else begin
              rem_reg   <= 32'd0;
              quo_reg   <= dividend_mag;
              div_reg   <= divisor_mag;
              q_neg_reg <= bus.op_signed & (bus.src1[31] ^ bus.src2[31]);
              r_neg_reg <= bus.op_signed & bus.src1[31];
              mod_reg   <= bus.op_mod;
            end
          end
        end
        BUSY: begin
          rem_reg   <= rem_step;
          quo_reg   <= quo_step;
          count_reg <= count_reg + 6'd1;
          if (count_reg == LAST_COUNT) begin
            result_reg <= result_sel;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Reset and flush gate the outputs combinationally so the stall drops in the same cycle.
  assign bus.pause_request = ~rst & ~bus.exception_flush & bus.op_valid & (state_reg != DONE);
  assign bus.result_valid  = ~rst & ~bus.exception_flush & (state_reg == DONE);
  assign bus.result        = rst ? 32'd0 : result_reg;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_div_if bus();

  ex_div #(
    .DIV_ZERO_Q(32'hFFFFFFFF),
    .ITERATIONS(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          s;
    bit          m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, truncating division, remainder takes the dividend's sign.
  function automatic logic [31:0] model(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return m ? a : 32'hFFFFFFFF;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return m ? r[31:0] : q[31:0];
  endfunction

  task automatic issue(input bit s, input bit m, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid  = 1'b1;
    bus.op_signed = s;
    bus.op_mod    = m;
    bus.src1      = a;
    bus.src2      = b;
  endtask

  // Called just after a negedge with the op presented; counts stall cycles until result_valid.
  task automatic wait_result(output logic [31:0] res, output int stall, output bit got);
    res   = 32'd0;
    stall = 0;
    got   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (bus.result_valid) begin
        res = bus.result;
        got = 1'b1;
        break;
      end
      if (bus.pause_request) stall++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input bit s, input bit m, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    logic [31:0] res;
    int          stall;
    bit          got;
    issue(s, m, a, b);
    wait_result(res, stall, got);
    check({name, " done"}, 32'(got), 32'd1);
    check({name, " result"}, res, exp);
    check({name, " stall"}, 32'(stall), 32'(exp_stall));
    $display("op %s s=%0d m=%0d a=%h b=%h -> result=%h stall=%0d", name, s, m, a, b, res, stall);
    bus.op_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand(input bit allow_zero);
    case ($urandom_range(0, 6))
      0:       return allow_zero ? 32'd0 : 32'd1;
      1:       return 32'($urandom_range(1, 20));
      2:       return 32'h80000000;
      3:       return 32'hFFFFFFFF;
      4:       return 32'($urandom_range(1, 1000));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res;
    int          stall;
    bit          got;
    int          early;

    vecs[0]  = '{"u 100/7",        0, 0, 32'd100,      32'd7,        32'd14,        33};
    vecs[1]  = '{"s -7%2",         1, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  33};
    vecs[2]  = '{"s -7/2",         1, 0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  33};
    vecs[3]  = '{"s ovf quo",      1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  33};
    vecs[4]  = '{"s ovf rem",      1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0,         33};
    vecs[5]  = '{"u max/1",        0, 0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  33};
    vecs[6]  = '{"u div0 quo",     0, 0, 32'h12345678, 32'd0,        32'hFFFFFFFF,  1};
    vecs[7]  = '{"u div0 rem",     0, 1, 32'h12345678, 32'd0,        32'h12345678,  1};
    vecs[8]  = '{"s div0 rem",     1, 1, 32'h87654321, 32'd0,        32'h87654321,  1};
    vecs[9]  = '{"u -7/2 raw",     0, 0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,  33};
    vecs[10] = '{"s 7%-2",         1, 1, 32'd7,        32'hFFFFFFFE, 32'd1,         33};
    vecs[11] = '{"u 100%7",        0, 1, 32'd100,      32'd7,        32'd2,         33};

    bus.exception_flush = 1'b0;
    bus.ex_stall        = 1'b0;
    bus.op_valid        = 1'b1;
    bus.op_signed       = 1'b0;
    bus.op_mod          = 1'b0;
    bus.src1            = 32'd100;
    bus.src2            = 32'd7;

    // Reset with an op pending: outputs must stay quiet.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset pause_request", 32'(bus.pause_request), 32'd0);
    check("reset result_valid", 32'(bus.result_valid), 32'd0);
    check("reset result", bus.result, 32'd0);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("idle result after reset", bus.result, 32'd0);
    check("idle pause_request", 32'(bus.pause_request), 32'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].s, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall);
    end

    // Flush at BUSY cycle 10, then the same op restarts from scratch.
    issue(0, 0, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    bus.exception_flush = 1'b1;
    #1;
    check("flush pause_request", 32'(bus.pause_request), 32'd0);
    check("flush result_valid", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    bus.exception_flush = 1'b0;
    wait_result(res, stall, got);
    check("after flush done", 32'(got), 32'd1);
    check("after flush result", res, 32'd14);
    check("after flush stall", 32'(stall), 32'd33);
    $display("op flush-restart 100/7 -> result=%h stall=%0d", res, stall);
    bus.op_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of BUSY.
    issue(1, 0, 32'hFFFFFF00, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy pause_request", 32'(bus.pause_request), 32'd0);
    check("rst busy result_valid", 32'(bus.result_valid), 32'd0);
    check("rst busy result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.op_valid = 1'b0;
    early = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.result_valid || bus.result != 32'd0) early++;
      @(negedge clk);
    end
    check("no result after rst", 32'(early), 32'd0);
    $display("op rst-mid-busy -> quiet for 40 cycles");

    // Downstream stall holds the result; release goes through one IDLE cycle.
    bus.ex_stall = 1'b1;
    issue(0, 0, 32'd100, 32'd7);
    wait_result(res, stall, got);
    check("stall first done", 32'(got), 32'd1);
    check("stall first result", res, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold valid %0d", i), 32'(bus.result_valid), 32'd1);
      check($sformatf("hold result %0d", i), bus.result, 32'd14);
      check($sformatf("hold pause %0d", i), 32'(bus.pause_request), 32'd0);
    end
    $display("op held result=%h for 5 stalled cycles", bus.result);
    bus.ex_stall = 1'b0;
    issue(0, 0, 32'd200, 32'd7);
    #1;
    check("release still done", 32'(bus.result_valid), 32'd1);
    @(negedge clk);
    wait_result(res, stall, got);
    check("second op done", 32'(got), 32'd1);
    check("second op result", res, 32'd28);
    check("second op stall", 32'(stall), 32'd33);
    $display("op back-to-back 200/7 -> result=%h stall=%0d", res, stall);
    bus.op_valid = 1'b0;
    @(negedge clk);

    // Randomized operations against the arithmetic model.
    for (int n = 0; n < 60; n++) begin
      bit          s, m;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      a = pick_operand(1'b1);
      b = pick_operand(($urandom_range(0, 7) == 0));
      run_op($sformatf("rand%0d", n), s, m, a, b, model(s, m, a, b), (b == 32'd0) ? 1 : 33);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
